// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: decode-side request and execute-side result.
// The master modport drives requests and result acceptance; the slave is the generator.
interface imm_gen_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       mode;
  logic [IN_W-1:0]  imm_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_out;
  logic             prefix_pending;

  modport master (
    output in_valid, mode, imm_in, out_ready,
    input  in_ready, out_valid, imm_out, prefix_pending
  );

  modport slave (
    input  in_valid, mode, imm_in, out_ready,
    output in_ready, out_valid, imm_out, prefix_pending
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator (SEXT/ZEXT/HI/BR) with a PREFIX op supplying upper bits.
// Optional err output is enabled by defining IMM_GEN_ERR_EN.
module imm_gen_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
`ifdef IMM_GEN_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int E = OUT_W - IN_W;

  typedef enum logic {IDLE, HELD} state_t;
  typedef enum logic [2:0] {
    M_SEXT   = 3'd0,
    M_ZEXT   = 3'd1,
    M_HI     = 3'd2,
    M_BR     = 3'd3,
    M_PREFIX = 3'd4
  } mode_t;

  state_t           state;
  logic [IN_W-1:0]  prefix_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] imm_q;

  logic             accept;
  logic             pending;
  logic             is_prefix;
  logic             is_rsvd;
  logic [OUT_W-1:0] sext_v;
  logic [OUT_W-1:0] zext_v;
  logic [OUT_W-1:0] pfx_v;
  logic [OUT_W-1:0] hi_v;
  logic [OUT_W-1:0] base_v;
  logic [OUT_W-1:0] next_imm;

  assign pending            = (state == HELD);
  assign bus.in_ready       = !flush && (!out_valid_q || bus.out_ready);
  assign bus.out_valid      = out_valid_q;
  assign bus.imm_out        = imm_q;
  assign bus.prefix_pending = pending;

  assign accept    = bus.in_valid && bus.in_ready;
  assign is_prefix = (bus.mode == M_PREFIX);
  assign is_rsvd   = (bus.mode > M_PREFIX);

  assign sext_v = {{E{bus.imm_in[IN_W-1]}}, bus.imm_in};
  assign zext_v = {{E{1'b0}}, bus.imm_in};
  assign pfx_v  = {prefix_q[E-1:0], bus.imm_in};
  assign hi_v   = {bus.imm_in, {E{1'b0}}};

  // A pending prefix replaces the extension bits for SEXT/ZEXT/BR; HI ignores it.
  always_comb begin
    base_v   = pending ? pfx_v : sext_v;
    next_imm = base_v;
    case (bus.mode)
      M_ZEXT:  next_imm = pending ? pfx_v : zext_v;
      M_HI:    next_imm = hi_v;
      M_BR:    next_imm = base_v << BR_SHIFT;
      default: next_imm = base_v;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prefix_q    <= '0;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
    end else if (flush) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      if (is_prefix) begin
        // Accept implies any held result was consumed this edge.
        prefix_q    <= bus.imm_in;
        state       <= HELD;
        out_valid_q <= 1'b0;
      end else begin
        imm_q       <= next_imm;
        out_valid_q <= 1'b1;
        state       <= IDLE;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef IMM_GEN_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= (flush && pending) ||
             (accept && ((is_prefix && pending) || is_rsvd));
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (IN_W=16, OUT_W=32, BR_SHIFT=1).
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;
  logic flush;
  int unsigned errors;
  int unsigned checks;

  imm_gen_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

`ifdef IMM_GEN_ERR_EN
  logic err;
`endif

  imm_gen_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef IMM_GEN_ERR_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.mode = 3'd0; bus.imm_in = '0; bus.out_ready = 1'b1;
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.imm_out !== 32'h0) begin errors++; $display("FAIL reset imm_out got=%h exp=00000000", bus.imm_out); end
    checks++; if (bus.prefix_pending !== 1'b0) begin errors++; $display("FAIL reset prefix_pending got=%b exp=0", bus.prefix_pending); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b exp=1", bus.in_ready); end
`ifdef IMM_GEN_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err got=%b exp=0", err); end
`endif
    #9 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_modes();
    logic [2:0]  v_mode [6] = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd3, 3'd3};
    logic [15:0] v_imm  [6] = '{16'h8001, 16'h8001, 16'h1234, 16'h8001, 16'hFFFE, 16'h0010};
    logic [31:0] v_exp  [6] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFF8001,
                                32'hFFFFFFFC, 32'h00000020};
    for (int i = 0; i < 6; i++) begin
      bus.mode = v_mode[i]; bus.imm_in = v_imm[i]; bus.in_valid = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL modes[%0d] out_valid got=%b exp=1", i, bus.out_valid); end
      checks++; if (bus.imm_out !== v_exp[i]) begin errors++; $display("FAIL modes[%0d] imm_out got=%h exp=%h", i, bus.imm_out, v_exp[i]); end
`ifdef IMM_GEN_ERR_EN
      checks++; if (err !== (v_mode[i] >= 3'd5)) begin errors++; $display("FAIL modes[%0d] err got=%b exp=%b", i, err, v_mode[i] >= 3'd5); end
`endif
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL modes_drain out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_prefix();
    bus.mode = 3'd4; bus.imm_in = 16'hDEAD; bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.prefix_pending !== 1'b1) begin errors++; $display("FAIL prefix pending got=%b exp=1", bus.prefix_pending); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL prefix out_valid got=%b exp=0", bus.out_valid); end
    bus.mode = 3'd0; bus.imm_in = 16'hBEEF;
    tick();
    checks++; if (bus.imm_out !== 32'hDEADBEEF) begin errors++; $display("FAIL prefix_sext imm_out got=%h exp=DEADBEEF", bus.imm_out); end
    checks++; if (bus.prefix_pending !== 1'b0) begin errors++; $display("FAIL prefix_consumed pending got=%b exp=0", bus.prefix_pending); end
    tick();
    checks++; if (bus.imm_out !== 32'hFFFFBEEF) begin errors++; $display("FAIL prefix_after imm_out got=%h exp=FFFFBEEF", bus.imm_out); end
    bus.mode = 3'd4; bus.imm_in = 16'h5555;
    tick();
    bus.mode = 3'd2; bus.imm_in = 16'h1234;
    tick();
    checks++; if (bus.imm_out !== 32'h12340000) begin errors++; $display("FAIL prefix_hi imm_out got=%h exp=12340000", bus.imm_out); end
    checks++; if (bus.prefix_pending !== 1'b0) begin errors++; $display("FAIL prefix_hi pending got=%b exp=0", bus.prefix_pending); end
    bus.mode = 3'd4; bus.imm_in = 16'h0001;
    tick();
    bus.mode = 3'd3; bus.imm_in = 16'h8000;
    tick();
    checks++; if (bus.imm_out !== 32'h00030000) begin errors++; $display("FAIL prefix_br imm_out got=%h exp=00030000", bus.imm_out); end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.mode = 3'd1; bus.imm_in = 16'h0005; bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.imm_out !== 32'h00000005) begin errors++; $display("FAIL bp_first imm_out got=%h exp=00000005", bus.imm_out); end
    bus.out_ready = 1'b0; bus.imm_in = 16'h0007;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready got=%b exp=0", bus.in_ready); end
    tick();
    tick();
    checks++; if (bus.imm_out !== 32'h00000005) begin errors++; $display("FAIL bp_hold imm_out got=%h exp=00000005", bus.imm_out); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold out_valid got=%b exp=1", bus.out_valid); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.imm_out !== 32'h00000007) begin errors++; $display("FAIL bp_second imm_out got=%h exp=00000007", bus.imm_out); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.mode = 3'd4; bus.imm_in = 16'h00AB; bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.prefix_pending !== 1'b1) begin errors++; $display("FAIL flush_pre pending got=%b exp=1", bus.prefix_pending); end
    flush = 1'b1; bus.mode = 3'd0; bus.imm_in = 16'h0009;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush in_ready got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.prefix_pending !== 1'b0) begin errors++; $display("FAIL flush pending got=%b exp=0", bus.prefix_pending); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid got=%b exp=0", bus.out_valid); end
`ifdef IMM_GEN_ERR_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL flush err got=%b exp=1", err); end
`endif
    flush = 1'b0; bus.imm_in = 16'h0001;
    tick();
    checks++; if (bus.imm_out !== 32'h00000001) begin errors++; $display("FAIL flush_after imm_out got=%h exp=00000001", bus.imm_out); end
`ifdef IMM_GEN_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_after err got=%b exp=0", err); end
`endif
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0; bus.mode = 3'd0; bus.imm_in = 16'h0033; bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.imm_out !== 32'h00000033) begin errors++; $display("FAIL rmid_pre imm_out got=%h exp=00000033", bus.imm_out); end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.imm_out !== 32'h0) begin errors++; $display("FAIL rmid imm_out got=%h exp=00000000", bus.imm_out); end
    rst_n = 1'b1; bus.out_ready = 1'b1;
    bus.mode = 3'd4; bus.imm_in = 16'h7777; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.prefix_pending !== 1'b0) begin errors++; $display("FAIL rmid pending got=%b exp=0", bus.prefix_pending); end
    rst_n = 1'b1;
    bus.mode = 3'd4; bus.imm_in = 16'h1111; bus.in_valid = 1'b1;
    tick();
`ifdef IMM_GEN_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pp_first err got=%b exp=0", err); end
`endif
    bus.imm_in = 16'h2222;
    tick();
`ifdef IMM_GEN_ERR_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL pp_second err got=%b exp=1", err); end
`endif
    bus.mode = 3'd1; bus.imm_in = 16'h0003;
    tick();
    checks++; if (bus.imm_out !== 32'h22220003) begin errors++; $display("FAIL pp_zext imm_out got=%h exp=22220003", bus.imm_out); end
    checks++; if (bus.prefix_pending !== 1'b0) begin errors++; $display("FAIL pp_zext pending got=%b exp=0", bus.prefix_pending); end
`ifdef IMM_GEN_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pp_zext err got=%b exp=0", err); end
`endif
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_modes();
    test_prefix();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate generator that sits between instruction decode and the operand-select mux of the execute stage.
- Extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign-extend, zero-extend, high-place or branch-scaled.
- Supports a two-instruction PREFIX sequence that supplies the upper immediate bits, allowing full-width constants.
- Valid/ready handshake on both sides; one output register stage.

Parameters:
- IN_W, 16, width of instruction immediate field.
- OUT_W, 32, width of generated immediate. Legal range IN_W < OUT_W <= 2*IN_W.
- BR_SHIFT, 1, left-shift applied in BR mode. Legal range 0..3.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; discards held output and pending prefix.
- in_valid  in  1  immediate/mode presented.
- in_ready  out  1  block can accept this cycle.
- mode  in  3  0=SEXT, 1=ZEXT, 2=HI, 3=BR, 4=PREFIX, 5-7 reserved.
- imm_in  in  IN_W  raw immediate.
- out_valid  out  1  imm_out holds a result.
- out_ready  in  1  consumer accepts result.
- imm_out  out  OUT_W  generated immediate.
- prefix_pending  out  1  a PREFIX has been captured and not yet consumed.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, imm_out=0, prefix_pending=0, prefix register=0. Reset mid-sequence discards everything.
- in_ready = !flush && (!out_valid || out_ready). Combinational, no dependence on in_valid.
- Accept = in_valid && in_ready.
- Latency: result appears on imm_out with out_valid=1 on the edge after accept.
- imm_out and out_valid hold while out_valid && !out_ready.
- If out_valid && out_ready && no accept, out_valid drops to 0 next edge.
- State machine, two states:
  - IDLE: prefix_pending=0.
  - HELD: prefix_pending=1.
  - IDLE -> HELD: accepted PREFIX. Stores imm_in in prefix register; no output produced; out_valid is unaffected, except that a consumed result clears it.
  - HELD -> IDLE: accepted non-PREFIX op, which consumes the prefix.
  - HELD -> HELD: accepted PREFIX overwrites the prefix register.
  - Any state -> IDLE: flush.
- Let E = OUT_W-IN_W, and P = low E bits of prefix register.
- Without a pending prefix:
  - SEXT = {E copies of imm_in[IN_W-1], imm_in}.
  - ZEXT = {E zeros, imm_in}.
  - HI = {imm_in, E zeros}, truncated to OUT_W bits.
  - BR = SEXT value << BR_SHIFT, truncated to OUT_W bits.
- With a pending prefix:
  - SEXT and ZEXT = {P, imm_in}.
  - BR = {P, imm_in} << BR_SHIFT, truncated.
  - HI ignores P; the prefix is still consumed.
- Reserved modes 5-7 behave as SEXT.
- Flush: out_valid=0 and prefix_pending=0 at the next edge. in_ready=0 during flush, so no accept occurs. imm_out value is don't-care but must not change while out_valid=1 without a handshake.
- No combinational path from imm_in or mode to imm_out.

Optional Feature:
- Macro: IMM_GEN_ERR_EN.
- When defined, adds output err (1 bit, reset 0). err is set for one cycle on the edge after any of:
  - an accepted PREFIX while prefix_pending=1;
  - an accepted reserved mode;
  - a flush while prefix_pending=1.
- When undefined, the err port and its logic are absent; all other behaviour is identical.

Test Plan:
- SEXT 0x8001, out_ready=1 -> next cycle imm_out=0xFFFF8001, out_valid=1. ZEXT 0x8001 -> 0x00008001.
- HI 0x1234 -> 0x12340000. BR 0xFFFE with BR_SHIFT=1 -> 0xFFFFFFFC. BR 0x0010 -> 0x00000020.
- PREFIX 0xDEAD, then SEXT 0xBEEF:
  - prefix_pending=1 after the first edge, no out_valid from the PREFIX;
  - then imm_out=0xDEADBEEF, prefix_pending=0.
  - A following SEXT 0xBEEF -> 0xFFFFBEEF.
- Backpressure: out_ready=0 with results 0x00000005 then ZEXT 0x0007 offered -> in_ready=0, imm_out holds 0x00000005. Raise out_ready -> 0x00000007 the next cycle, no loss or duplication.
- Flush: PREFIX 0x00AB accepted, then flush=1 with in_valid=1 -> in_ready=0; prefix_pending=0 and out_valid=0 next edge. Subsequent SEXT 0x0001 -> 0x00000001. With IMM_GEN_ERR_EN, err pulses once.
- Reset mid-operation: assert rst_n=0 while out_valid=1 and prefix_pending=1 -> all outputs 0 immediately. PREFIX 0x1111 then PREFIX 0x2222 then ZEXT 0x0003 -> 0x22220003; with IMM_GEN_ERR_EN, err=1 for exactly one cycle after the second PREFIX.
